aes_state_mem: RTL and testbench

Parametrised AES state/key memory, the successor to the 16-byte cipher memory. It holds a 16-byte state bank and a 16-byte round-key bank, and the host reads and writes both through a byte-wide or word-wide bus. It runs AddRoundKey, ShiftRows and MixColumns in place as multi-cycle operations with a busy/done handshake. It sits between the host bus and the round controller; SubBytes stays in a separate S-box block.

---
 rtl/aes_state_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_state_mem.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_state_mem.sv
`default_nettype none
// ============================================================================
// Module      : aes_state_mem
// Description : AES state / round-key memory with host byte/word access and
//               in-place AddRoundKey, ShiftRows and MixColumns operations
//               run under a busy/done handshake.
//               Optional macro AES_INV_OPS_EN adds InvShiftRows (op 4) and
//               InvMixColumns (op 5).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_state_mem #(
    parameter  int BUS_W          = 8,
    parameter  int COLS_PER_CYCLE = 1,
    localparam int AW             = $clog2(128 / BUS_W)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cs,
    input  logic             RW,
    input  logic             sel,
    input  logic [AW-1:0]    address,
    input  logic [BUS_W-1:0] DataIN,
    output logic [BUS_W-1:0] DataOut,
    input  logic             op_start,
    input  logic [2:0]       op_code,
    output logic             busy,
    output logic             done,
    output logic             op_err
);

    localparam int       c_bpw       = BUS_W / 8;
    localparam int       c_mix_steps = 4 / COLS_PER_CYCLE;
    localparam bit [1:0] c_last_cnt  = 2'(c_mix_steps - 1);

    localparam logic [2:0] c_op_ark   = 3'd0;
    localparam logic [2:0] c_op_shift = 3'd1;
    localparam logic [2:0] c_op_mix   = 3'd2;
`ifdef AES_INV_OPS_EN
    localparam logic [2:0] c_op_ishift = 3'd4;
    localparam logic [2:0] c_op_imix   = 3'd5;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    fsm_t             r_fsm;
    logic [7:0]       r_st  [16];
    logic [7:0]       r_key [16];
    logic [7:0]       w_st_next [16];
    logic [BUS_W-1:0] r_dout;
    logic [2:0]       r_op;
    logic [1:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_last;
    logic             w_unsup;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one column; row 0 sits in bits [31:24]
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef AES_INV_OPS_EN
    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction
    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction
    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction
    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Inverse MixColumns on one column
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
    endfunction
`endif

    // Host lanes: lane 0 is the lowest byte address and the top of the bus
    logic [3:0]       w_lane_idx [c_bpw];
    logic [BUS_W-1:0] w_rd_word;

    generate
        for (genvar b = 0; b < c_bpw; b++) begin : g_lane
            assign w_lane_idx[b] = 4'(int'(address) * c_bpw + b);
            assign w_rd_word[BUS_W-1-8*b -: 8] =
                sel ? r_key[w_lane_idx[b]] : r_st[w_lane_idx[b]];
        end
    endgenerate

    // MixColumns slots: slot j handles column r_cnt*COLS_PER_CYCLE + j
    logic [1:0]  w_slot_col [COLS_PER_CYCLE];
    logic [31:0] w_slot_in  [COLS_PER_CYCLE];
    logic [31:0] w_slot_fwd [COLS_PER_CYCLE];
`ifdef AES_INV_OPS_EN
    logic [31:0] w_slot_inv [COLS_PER_CYCLE];
`endif

    generate
        for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix_slot
            assign w_slot_col[j] = 2'(int'(r_cnt) * COLS_PER_CYCLE + j);
            assign w_slot_in[j]  = {r_st[{w_slot_col[j], 2'd0}],
                                    r_st[{w_slot_col[j], 2'd1}],
                                    r_st[{w_slot_col[j], 2'd2}],
                                    r_st[{w_slot_col[j], 2'd3}]};
            assign w_slot_fwd[j] = mix_col(w_slot_in[j]);
`ifdef AES_INV_OPS_EN
            assign w_slot_inv[j] = inv_mix_col(w_slot_in[j]);
`endif
        end
    endgenerate

    // Next state-bank value for the current RUN cycle
    always_comb begin
        w_unsup = 1'b0;
        w_last  = 1'b1;
        for (int i = 0; i < 16; i++) w_st_next[i] = r_st[i];
        case (r_op)
            c_op_ark: begin
                for (int i = 0; i < 16; i++) w_st_next[i] = r_st[i] ^ r_key[i];
            end
            c_op_shift: begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        w_st_next[r + 4*c] = r_st[r + 4*((c + r) % 4)];
            end
            c_op_mix: begin
                w_last = (r_cnt == c_last_cnt);
                for (int j = 0; j < COLS_PER_CYCLE; j++)
                    for (int r = 0; r < 4; r++)
                        w_st_next[{w_slot_col[j], 2'(r)}] = w_slot_fwd[j][31-8*r -: 8];
            end
`ifdef AES_INV_OPS_EN
            c_op_ishift: begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        w_st_next[r + 4*c] = r_st[r + 4*((c - r + 4) % 4)];
            end
            c_op_imix: begin
                w_last = (r_cnt == c_last_cnt);
                for (int j = 0; j < COLS_PER_CYCLE; j++)
                    for (int r = 0; r < 4; r++)
                        w_st_next[{w_slot_col[j], 2'(r)}] = w_slot_inv[j][31-8*r -: 8];
            end
`endif
            default: w_unsup = 1'b1;
        endcase
    end

    // Control FSM, host access and in-place bank update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                r_st[i]  <= '0;
                r_key[i] <= '0;
            end
            r_dout <= '0;
            r_fsm  <= S_IDLE;
            r_op   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_fsm == S_IDLE) begin
                if (op_start) begin
                    // a start request takes priority over a host access
                    r_fsm  <= S_RUN;
                    r_op   <= op_code;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end else if (cs) begin
                    if (RW) begin
                        r_dout <= w_rd_word;
                    end else begin
                        for (int b = 0; b < c_bpw; b++) begin
                            if (sel) r_key[w_lane_idx[b]] <= DataIN[BUS_W-1-8*b -: 8];
                            else     r_st[w_lane_idx[b]]  <= DataIN[BUS_W-1-8*b -: 8];
                        end
                    end
                end
            end else begin
                for (int i = 0; i < 16; i++) r_st[i] <= w_st_next[i];
                if (w_last) begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_err  <= w_unsup;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    assign DataOut = r_dout;
    assign busy    = r_busy;
    assign done    = r_done;
    assign op_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_state_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_state_mem
// Description : Self-checking bench for aes_state_mem; an 8-bit/1-column
//               instance and a 32-bit/4-column instance against a
//               matrix-level AES reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_state_mem;

`ifdef AES_INV_OPS_EN
    localparam bit c_inv = 1'b1;
`else
    localparam bit c_inv = 1'b0;
`endif

    typedef logic [15:0][7:0] bank_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_cs, a_rw, a_sel, a_start, a_busy, a_done, a_err;
    logic [3:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_code;
    logic        b_cs, b_rw, b_sel, b_start, b_busy, b_done, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_din, b_dout;
    logic [2:0]  b_code;

    aes_state_mem #(.BUS_W(8), .COLS_PER_CYCLE(1)) u_a (
        .CLK(clk), .RST(rst), .cs(a_cs), .RW(a_rw), .sel(a_sel), .address(a_addr),
        .DataIN(a_din), .DataOut(a_dout), .op_start(a_start), .op_code(a_code),
        .busy(a_busy), .done(a_done), .op_err(a_err));

    aes_state_mem #(.BUS_W(32), .COLS_PER_CYCLE(4)) u_b (
        .CLK(clk), .RST(rst), .cs(b_cs), .RW(b_rw), .sel(b_sel), .address(b_addr),
        .DataIN(b_din), .DataOut(b_dout), .op_start(b_start), .op_code(b_code),
        .busy(b_busy), .done(b_done), .op_err(b_err));

    int checks   = 0;
    int failures = 0;
    bank_t ma_st, ma_key, mb_st, mb_key, saved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (matrix view, field arithmetic) -------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11b) << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int k);
        logic [7:0] f [4];
        logic [7:0] g [4];
        f = '{8'h02, 8'h03, 8'h01, 8'h01};
        g = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        return inv ? g[k] : f[k];
    endfunction

    function automatic bit model_err(input int code);
        if (code <= 2) return 1'b0;
        if (c_inv && (code == 4 || code == 5)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_busy(input int code, input int cpc);
        if (code == 2 || (c_inv && code == 5)) return 4 / cpc;
        return 1;
    endfunction

    function automatic bank_t model_apply(input bank_t st, input bank_t key, input int code);
        bank_t n;
        logic [7:0] acc;
        n = st;
        if (code == 0) begin
            for (int i = 0; i < 16; i++) n[i] = st[i] ^ key[i];
        end else if (code == 1 || (c_inv && code == 4)) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    n[r + 4*c] = (code == 1) ? st[r + 4*((c + r) % 4)]
                                             : st[r + 4*((c + 4 - r) % 4)];
        end else if (code == 2 || (c_inv && code == 5)) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc ^= gm(coef(code == 5, (k - r + 4) % 4), st[k + 4*c]);
                    n[r + 4*c] = acc;
                end
        end
        return n;
    endfunction

    // ---------------- instance A (byte bus) ---------------------------------
    task automatic a_write(input logic s, input int addr, input logic [7:0] d);
        a_cs = 1; a_rw = 0; a_sel = s; a_addr = 4'(addr); a_din = d;
        @(posedge clk); #1;
        a_cs = 0;
    endtask

    task automatic a_read(input logic s, input int addr, output logic [7:0] d);
        a_cs = 1; a_rw = 1; a_sel = s; a_addr = 4'(addr);
        @(posedge clk); #1;
        a_cs = 0;
        d = a_dout;
    endtask

    task automatic a_load(input logic s, input bank_t v);
        for (int i = 0; i < 16; i++) a_write(s, i, v[i]);
    endtask

    task automatic a_check_bank(input string tag, input logic s, input bank_t exp);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            a_read(s, i, d);
            check($sformatf("%s[%0d]", tag, i), 32'(d), 32'(exp[i]));
        end
    endtask

    task automatic a_op(input string tag, input int code);
        int n;
        n = 0;
        a_start = 1; a_code = 3'(code);
        @(posedge clk); #1;
        a_start = 0; a_cs = 0;
        while (a_busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, ".busy_cycles"}, 32'(n), 32'(model_busy(code, 1)));
        check({tag, ".done"}, 32'(a_done), 32'd1);
        check({tag, ".op_err"}, 32'(a_err), 32'(model_err(code)));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(a_done), 32'd0);
        ma_st = model_apply(ma_st, ma_key, code);
    endtask

    // ---------------- instance B (word bus) ---------------------------------
    task automatic b_write(input logic s, input int addr, input logic [31:0] d);
        b_cs = 1; b_rw = 0; b_sel = s; b_addr = 2'(addr); b_din = d;
        @(posedge clk); #1;
        b_cs = 0;
    endtask

    task automatic b_check_bank(input string tag, input logic s, input bank_t exp);
        for (int k = 0; k < 4; k++) begin
            b_cs = 1; b_rw = 1; b_sel = s; b_addr = 2'(k);
            @(posedge clk); #1;
            b_cs = 0;
            check($sformatf("%s.w%0d", tag, k), b_dout,
                  {exp[4*k], exp[4*k+1], exp[4*k+2], exp[4*k+3]});
        end
    endtask

    task automatic b_op(input string tag, input int code);
        int n;
        n = 0;
        b_start = 1; b_code = 3'(code);
        @(posedge clk); #1;
        b_start = 0;
        while (b_busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, ".busy_cycles"}, 32'(n), 32'(model_busy(code, 4)));
        check({tag, ".done"}, 32'(b_done), 32'd1);
        check({tag, ".op_err"}, 32'(b_err), 32'(model_err(code)));
        @(posedge clk); #1;
        mb_st = model_apply(mb_st, mb_key, code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] d, held;
        logic [7:0] sr_tab [16];
        logic [7:0] mix_in [16];
        logic [7:0] mix_out [16];
        int n, code;

        sr_tab  = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                    8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
        mix_in  = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
                    8'hf2, 8'h0a, 8'h22, 8'h5c, 8'hf2, 8'h0a, 8'h22, 8'h5c};
        mix_out = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
                    8'h9f, 8'hdc, 8'h58, 8'h9d, 8'h9f, 8'hdc, 8'h58, 8'h9d};

        rst = 1;
        a_cs = 0; a_rw = 0; a_sel = 0; a_addr = 0; a_din = 0; a_start = 0; a_code = 0;
        b_cs = 0; b_rw = 0; b_sel = 0; b_addr = 0; b_din = 0; b_start = 0; b_code = 0;
        ma_st = '0; ma_key = '0; mb_st = '0; mb_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.a_dout", 32'(a_dout), 32'd0);
        check("rst.a_busy", 32'(a_busy), 32'd0);
        check("rst.a_done", 32'(a_done), 32'd0);
        check("rst.a_err",  32'(a_err),  32'd0);
        check("rst.b_dout", b_dout, 32'd0);
        check("rst.b_busy", 32'(b_busy), 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // byte write / read-back with 1-cycle latency
        for (int i = 0; i < 16; i++) ma_st[i] = 8'(i);
        a_load(0, ma_st);
        a_check_bank("rdback", 0, ma_st);
        held = a_dout;
        @(posedge clk); #1;
        check("dout_hold", 32'(a_dout), 32'(held));

        // AddRoundKey with key all FF
        for (int i = 0; i < 16; i++) ma_key[i] = 8'hff;
        a_load(1, ma_key);
        a_op("ark", 0);
        a_check_bank("ark.st", 0, ma_st);
        a_check_bank("ark.key", 1, ma_key);

        // ShiftRows against the published table
        for (int i = 0; i < 16; i++) ma_st[i] = 8'(i);
        a_load(0, ma_st);
        a_op("shr", 1);
        for (int i = 0; i < 16; i++) ma_st[i] = sr_tab[i];
        a_check_bank("shr.st", 0, ma_st);

        // MixColumns known-answer vector
        for (int i = 0; i < 16; i++) ma_st[i] = mix_in[i];
        a_load(0, ma_st);
        a_op("mix", 2);
        for (int i = 0; i < 16; i++) ma_st[i] = mix_out[i];
        a_check_bank("mix.st", 0, ma_st);
        a_check_bank("mix.key", 1, ma_key);

        // op_start and a write in the same cycle: the write is dropped
        a_cs = 1; a_rw = 0; a_sel = 0; a_addr = 0; a_din = 8'h55;
        a_op("collide", 0);
        a_check_bank("collide.st", 0, ma_st);

        // accesses and op_start during a 4-cycle MixColumns are ignored
        a_read(0, 5, held);
        a_start = 1; a_code = 3'd2;
        @(posedge clk); #1;
        a_start = 0;
        check("ign.busy", 32'(a_busy), 32'd1);
        a_cs = 1; a_rw = 0; a_sel = 0; a_addr = 4'd3; a_din = 8'haa;
        @(posedge clk); #1;
        a_rw = 1; a_addr = 4'd9;
        @(posedge clk); #1;
        check("ign.dout", 32'(a_dout), 32'(held));
        a_cs = 0; a_start = 1; a_code = 3'd0;
        @(posedge clk); #1;
        a_start = 0;
        n = 0;
        while (a_done !== 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("ign.done", 32'(a_done), 32'd1);
        @(posedge clk); #1;
        check("ign.no_restart", 32'(a_busy), 32'd0);
        ma_st = model_apply(ma_st, ma_key, 2);
        a_check_bank("ign.st", 0, ma_st);

        // back-to-back: new start accepted in the done cycle
        a_start = 1; a_code = 3'd1;
        @(posedge clk); #1;
        a_start = 0;
        @(posedge clk); #1;
        check("b2b.done1", 32'(a_done), 32'd1);
        a_start = 1;
        @(posedge clk); #1;
        a_start = 0;
        check("b2b.busy2", 32'(a_busy), 32'd1);
        @(posedge clk); #1;
        check("b2b.done2", 32'(a_done), 32'd1);
        ma_st = model_apply(model_apply(ma_st, ma_key, 1), ma_key, 1);
        a_check_bank("b2b.st", 0, ma_st);

        // randomized operations on both banks
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) begin
                ma_st[i]  = 8'($urandom);
                ma_key[i] = 8'($urandom);
            end
            a_load(0, ma_st);
            a_load(1, ma_key);
            code = (it < 3) ? it : int'($urandom_range(0, 7));
            a_op($sformatf("rnd%0d.op%0d", it, code), code);
            a_check_bank($sformatf("rnd%0d.st", it), 0, ma_st);
        end

`ifdef AES_INV_OPS_EN
        // inverse pairs restore the original state
        for (int i = 0; i < 16; i++) ma_st[i] = 8'($urandom);
        a_load(0, ma_st);
        saved = ma_st;
        a_op("inv.mix", 2);
        a_op("inv.imix", 5);
        a_check_bank("inv.mixpair", 0, saved);
        a_op("inv.shr", 1);
        a_op("inv.ishr", 4);
        a_check_bank("inv.shrpair", 0, saved);
`endif

        // word bus: lane order, ops, busy-time access rejection
        b_write(0, 0, 32'h00010203);
        mb_st[0] = 8'h00; mb_st[1] = 8'h01; mb_st[2] = 8'h02; mb_st[3] = 8'h03;
        b_check_bank("w.wr", 0, mb_st);
        b_start = 1; b_code = 3'd2;
        @(posedge clk); #1;
        check("w.busy", 32'(b_busy), 32'd1);
        b_code = 3'd0;
        b_cs = 1; b_rw = 0; b_sel = 0; b_addr = 2'd1; b_din = 32'hdeadbeef;
        @(posedge clk); #1;
        check("w.done", 32'(b_done), 32'd1);
        check("w.busy_len", 32'(b_busy), 32'd0);
        b_cs = 0; b_start = 0;
        @(posedge clk); #1;
        check("w.no_restart", 32'(b_busy), 32'd0);
        mb_st = model_apply(mb_st, mb_key, 2);
        b_check_bank("w.mix", 0, mb_st);
        b_op("w.op7", 7);
        b_check_bank("w.op7.st", 0, mb_st);
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 4; k++) begin
                b_din = $urandom;
                b_write(0, k, b_din);
                {mb_st[4*k], mb_st[4*k+1], mb_st[4*k+2], mb_st[4*k+3]} = b_din;
                b_din = $urandom;
                b_write(1, k, b_din);
                {mb_key[4*k], mb_key[4*k+1], mb_key[4*k+2], mb_key[4*k+3]} = b_din;
            end
            code = (it == 0) ? 2 : int'($urandom_range(0, 7));
            b_op($sformatf("wrnd%0d.op%0d", it, code), code);
            b_check_bank($sformatf("wrnd%0d.st", it), 0, mb_st);
        end

        // reset in the middle of MixColumns
        a_read(0, 1, d);
        a_start = 1; a_code = 3'd2;
        @(posedge clk); #1;
        a_start = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("mrst.busy", 32'(a_busy), 32'd0);
        check("mrst.dout", 32'(a_dout), 32'd0);
        @(posedge clk); #1;
        check("mrst.done", 32'(a_done), 32'd0);
        rst = 0;
        ma_st = '0; ma_key = '0; mb_st = '0; mb_key = '0;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) n++;
        end
        check("mrst.no_done", 32'(n), 32'd0);
        a_check_bank("mrst.st", 0, ma_st);
        a_check_bank("mrst.key", 1, ma_key);
        b_check_bank("mrst.wst", 0, mb_st);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
